// File: rtl/ascii_dec_parser.sv
// ASCII decimal parser: packs '0'..'9' bytes into a BCD word, released on TERM.
// Optional sign support ('-' prefix, neg_out port) is enabled by ASCII_DEC_SIGN_EN.
module ascii_dec_parser #(
  parameter int unsigned NDIG = 4,
  parameter logic [7:0]  TERM = 8'h0D
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [4*NDIG-1:0]          bcd_out,
  output logic                       num_valid,
  output logic [$clog2(NDIG+1)-1:0]  dig_cnt,
  output logic                       err,
  output logic                       busy
`ifdef ASCII_DEC_SIGN_EN
  ,
  output logic                       neg_out
`endif
);

  localparam int unsigned CW = $clog2(NDIG + 1);
  localparam int unsigned AW = 4 * NDIG;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] ERROR = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] bcd_d;
  logic [CW-1:0] dig_cnt_d;
  logic          num_valid_d, err_d, to_err;
  logic          is_digit, is_term;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term  = (rx_data == TERM);
  assign busy     = (state_q != IDLE);

`ifdef ASCII_DEC_SIGN_EN
  logic neg_q, neg_d, neg_out_d, is_minus;
  assign is_minus = (rx_data == 8'h2D);
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_out;
    dig_cnt_d   = dig_cnt;
    num_valid_d = 1'b0;
    err_d       = 1'b0;
    to_err      = 1'b0;
`ifdef ASCII_DEC_SIGN_EN
    neg_d       = neg_q;
    neg_out_d   = neg_out;
`endif
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (is_digit) begin
            state_d = ACCUM;
            acc_d   = AW'(rx_data[3:0]);
            cnt_d   = CW'(1);
`ifdef ASCII_DEC_SIGN_EN
            neg_d   = 1'b0;
          end else if (is_minus) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            neg_d   = 1'b1;
`endif
          end else if (!is_term) begin
            to_err = 1'b1;
          end
        end
        ACCUM: begin
          if (is_digit) begin
            if (cnt_q == CW'(NDIG)) begin
              to_err = 1'b1;
            end else begin
              acc_d = {acc_q[AW-5:0], rx_data[3:0]};
              cnt_d = cnt_q + CW'(1);
            end
          end else if (is_term) begin
`ifdef ASCII_DEC_SIGN_EN
            // A lone '-' carries no digits and is not a number.
            if (cnt_q == '0) begin
              to_err = 1'b1;
            end else begin
              neg_out_d = neg_q;
              neg_d     = 1'b0;
`else
            begin
`endif
              bcd_d       = acc_q;
              dig_cnt_d   = cnt_q;
              num_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              state_d     = IDLE;
            end
          end else begin
            to_err = 1'b1;
          end
        end
        ERROR: begin
          if (is_term) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Error entry discards the partial number; outputs keep the last good one.
    if (to_err) begin
      state_d = ERROR;
      acc_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b1;
`ifdef ASCII_DEC_SIGN_EN
      neg_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      bcd_out   <= '0;
      dig_cnt   <= '0;
      num_valid <= 1'b0;
      err       <= 1'b0;
`ifdef ASCII_DEC_SIGN_EN
      neg_q     <= 1'b0;
      neg_out   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      bcd_out   <= bcd_d;
      dig_cnt   <= dig_cnt_d;
      num_valid <= num_valid_d;
      err       <= err_d;
`ifdef ASCII_DEC_SIGN_EN
      neg_q     <= neg_d;
      neg_out   <= neg_out_d;
`endif
    end
  end

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Directed bench for ascii_dec_parser: one table row per clock, plus corner sequences.
module tb_ascii_dec_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] bcd_out;
  logic        num_valid;
  logic [2:0]  dig_cnt;
  logic        err;
  logic        busy;
`ifdef ASCII_DEC_SIGN_EN
  logic        neg_out;
`endif

  ascii_dec_parser #(.NDIG(4), .TERM(8'h0D)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .bcd_out   (bcd_out),
    .num_valid (num_valid),
    .dig_cnt   (dig_cnt),
    .err       (err),
    .busy      (busy)
`ifdef ASCII_DEC_SIGN_EN
    ,
    .neg_out   (neg_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic [15:0] bcd;
    logic [2:0]  cnt;
    logic        nv;
    logic        er;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic [15:0] bcd,
                     input logic [2:0] cnt, input logic nv, input logic er, input logic bsy);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.bcd = bcd; t.cnt = cnt; t.nv = nv; t.er = er; t.bsy = bsy;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one byte on the falling edge, then sample just after the rising edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst      = r;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] bcd, input logic [2:0] cnt,
                         input logic nv, input logic er, input logic bsy);
    chk({tag, " bcd_out"}, 32'(bcd_out), 32'(bcd));
    chk({tag, " dig_cnt"}, 32'(dig_cnt), 32'(cnt));
    chk({tag, " num_valid"}, 32'(num_valid), 32'(nv));
    chk({tag, " err"}, 32'(err), 32'(er));
    chk({tag, " busy"}, 32'(busy), 32'(bsy));
  endtask

  initial begin
    // reset
    add(1, 0, 8'h00, 16'h0000, 0, 0, 0, 0);
    // "1234" CR
    add(0, 1, 8'h31, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 8'h32, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 8'h33, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 8'h34, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 8'h0D, 16'h1234, 4, 1, 0, 0);
    add(0, 0, 8'h31, 16'h1234, 4, 0, 0, 0);   // data ignored without rx_valid
    // "7" CR back-to-back
    add(0, 1, 8'h37, 16'h1234, 4, 0, 0, 1);
    add(0, 1, 8'h0D, 16'h0007, 1, 1, 0, 0);
    add(0, 0, 8'h00, 16'h0007, 1, 0, 0, 0);
    // "12345" overflows on the fifth digit
    add(0, 1, 8'h31, 16'h0007, 1, 0, 0, 1);
    add(0, 1, 8'h32, 16'h0007, 1, 0, 0, 1);
    add(0, 1, 8'h33, 16'h0007, 1, 0, 0, 1);
    add(0, 1, 8'h34, 16'h0007, 1, 0, 0, 1);
    add(0, 1, 8'h35, 16'h0007, 1, 0, 1, 1);
    add(0, 0, 8'h00, 16'h0007, 1, 0, 0, 1);
    add(0, 1, 8'h0D, 16'h0007, 1, 0, 0, 0);
    add(0, 1, 8'h39, 16'h0007, 1, 0, 0, 1);
    add(0, 1, 8'h0D, 16'h0009, 1, 1, 0, 0);
    // "4A5" CR then lone CR
    add(0, 1, 8'h34, 16'h0009, 1, 0, 0, 1);
    add(0, 1, 8'h41, 16'h0009, 1, 0, 1, 1);
    add(0, 1, 8'h35, 16'h0009, 1, 0, 0, 1);
    add(0, 1, 8'h0D, 16'h0009, 1, 0, 0, 0);
    add(0, 1, 8'h0D, 16'h0009, 1, 0, 0, 0);
    // bad byte straight from IDLE
    add(0, 1, 8'h2F, 16'h0009, 1, 0, 1, 1);
    add(0, 1, 8'h0D, 16'h0009, 1, 0, 0, 0);
    // "56", reset, "8" CR
    add(0, 1, 8'h35, 16'h0009, 1, 0, 0, 1);
    add(0, 1, 8'h36, 16'h0009, 1, 0, 0, 1);
    add(1, 0, 8'h00, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 8'h38, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 8'h0D, 16'h0008, 1, 1, 0, 0);
    add(0, 0, 8'h00, 16'h0008, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d);
      chk_all($sformatf("v%0d", i), tbl[i].bcd, tbl[i].cnt, tbl[i].nv, tbl[i].er, tbl[i].bsy);
    end

    // Reset acts without a clock edge.
    step(0, 1, 8'h31);
    chk("pre-async busy", 32'(busy), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("async-rst", 16'h0000, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-async busy", 32'(busy), 32'd0);

`ifdef ASCII_DEC_SIGN_EN
    step(0, 1, 8'h2D);
    chk_all("s-minus", 16'h0000, 0, 0, 0, 1);
    step(0, 1, 8'h34);
    step(0, 1, 8'h32);
    step(0, 1, 8'h0D);
    chk_all("s-neg42", 16'h0042, 2, 1, 0, 0);
    chk("s-neg42 neg_out", 32'(neg_out), 32'd1);
    step(0, 1, 8'h2D);
    step(0, 1, 8'h0D);
    chk_all("s-lone", 16'h0042, 2, 0, 1, 1);
    chk("s-lone neg_out", 32'(neg_out), 32'd1);
    step(0, 1, 8'h0D);
    chk("s-lone idle", 32'(busy), 32'd0);
    step(0, 1, 8'h33);
    step(0, 1, 8'h2D);
    chk_all("s-3minus", 16'h0042, 2, 0, 1, 1);
    step(0, 1, 8'h0D);
    step(0, 1, 8'h35);
    step(0, 1, 8'h0D);
    chk_all("s-pos5", 16'h0005, 1, 1, 0, 0);
    chk("s-pos5 neg_out", 32'(neg_out), 32'd0);
`else
    step(0, 1, 8'h2D);
    chk_all("minus-bad", 16'h0000, 0, 0, 1, 1);
    step(0, 1, 8'h0D);
    chk_all("minus-recover", 16'h0000, 0, 0, 0, 0);
`endif

    step(0, 0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
